// File: rtl/rctimer_pkg.sv
// Shared types and widths for the SegmentRunner
// timer speed controller.
package rctimer_pkg;

  localparam int CFG_W   = 10;
  localparam int LEVEL_W = 4;
  localparam int CNT_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  function automatic logic [LEVEL_W-1:0] sat_inc(
    input logic [LEVEL_W-1:0] v,
    input logic [LEVEL_W-1:0] max_v
  );
    return (v >= max_v) ? max_v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rctimer_speed_ctrl_period_stepper.sv
// Next-period computation: subtract one step,
// clamp to the floor (11-bit so underflow clamps).
module period_stepper
  import rctimer_pkg::*;
#(
  parameter logic [CFG_W-1:0] MIN_PERIOD  = 10'd50,
  parameter logic [CFG_W-1:0] PERIOD_STEP = 10'd25
) (
  input  logic [CFG_W-1:0] cur_period,
  output logic [CFG_W-1:0] next_period
);

  logic [CFG_W:0] diff;

  assign diff = {1'b0, cur_period} - {1'b0, PERIOD_STEP};

  assign next_period =
    (diff[CFG_W] || (diff[CFG_W-1:0] < MIN_PERIOD))
      ? MIN_PERIOD
      : diff[CFG_W-1:0];

endmodule

// File: rtl/rctimer_speed_ctrl.sv
// Start/pause/stop sequencer for Timer_rc with
// tick-driven level-up and period shortening.
module rctimer_speed_ctrl
  import rctimer_pkg::*;
#(
  parameter logic [CFG_W-1:0]   INIT_PERIOD     = 10'd500,
  parameter logic [CFG_W-1:0]   MIN_PERIOD      = 10'd50,
  parameter logic [CFG_W-1:0]   PERIOD_STEP     = 10'd25,
  parameter int                 TICKS_PER_LEVEL = 16,
  parameter logic [LEVEL_W-1:0] MAX_LEVEL       = 4'd15
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Pause,
  input  logic               Stop,
  input  logic               TmrTick,
  output logic               TmrEnable,
  output logic               TmrClear,
  output logic [CFG_W-1:0]   TmrCfg,
  output logic               GameTick,
  output logic [LEVEL_W-1:0] Level,
  output logic               Running
);

  localparam logic [CNT_W-1:0] TPL =
    CNT_W'(TICKS_PER_LEVEL);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CFG_W-1:0] cfg_next;
  logic             level_up;

  assign cnt_inc  = cnt + 1'b1;
  assign level_up = TmrTick && (cnt_inc == TPL);

  period_stepper #(
    .MIN_PERIOD  (MIN_PERIOD),
    .PERIOD_STEP (PERIOD_STEP)
  ) u_stepper (
    .cur_period  (TmrCfg),
    .next_period (cfg_next)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      TmrEnable <= 1'b0;
      TmrClear  <= 1'b1;
      TmrCfg    <= INIT_PERIOD;
      GameTick  <= 1'b0;
      Level     <= '0;
      Running   <= 1'b0;
      cnt       <= '0;
    end else begin
      GameTick <= 1'b0;
      unique case (state)
        S_IDLE, S_HALT: begin
          TmrEnable <= 1'b0;
          TmrClear  <= 1'b1;
          Running   <= 1'b0;
          if (Start) state <= S_LOAD;
        end
        S_LOAD: begin
          state     <= S_RUN;
          TmrEnable <= 1'b1;
          TmrClear  <= 1'b0;
          Running   <= 1'b1;
          TmrCfg    <= INIT_PERIOD;
          Level     <= '0;
          cnt       <= '0;
        end
        S_RUN: begin
          if (Stop) begin
            state     <= S_HALT;
            TmrEnable <= 1'b0;
            TmrClear  <= 1'b1;
            Running   <= 1'b0;
          end else begin
            TmrClear <= 1'b0;
            if (TmrTick) begin
              GameTick <= 1'b1;
              if (level_up) begin
                cnt      <= '0;
                Level    <= sat_inc(Level, MAX_LEVEL);
                TmrCfg   <= cfg_next;
                TmrClear <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
            // tick above is taken before pausing
            if (Pause) begin
              state     <= S_PAUSED;
              TmrEnable <= 1'b0;
              Running   <= 1'b0;
            end
          end
        end
        S_PAUSED: begin
          if (Stop) begin
            state     <= S_HALT;
            TmrEnable <= 1'b0;
            TmrClear  <= 1'b1;
            Running   <= 1'b0;
          end else begin
            TmrClear <= 1'b0;
            if (Pause) begin
              state     <= S_RUN;
              TmrEnable <= 1'b1;
              Running   <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          TmrEnable <= 1'b0;
          TmrClear  <= 1'b1;
          Running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rctimer_speed_ctrl.sv
// Bench: table vectors, hand sequences and random
// stimulus against a tick-total reference model.
`timescale 1ns/100ps
module tb_rctimer_speed_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Stop = 1'b0;
  logic       TmrTick = 1'b0;

  logic       en_a, clr_a, gt_a, run_a;
  logic [9:0] cfg_a;
  logic [3:0] lvl_a;
  logic       en_b, clr_b, gt_b, run_b;
  logic [9:0] cfg_b;
  logic [3:0] lvl_b;

  int checks = 0;
  int failures = 0;

  always #1 Clk = ~Clk;

  rctimer_speed_ctrl #(
    .TICKS_PER_LEVEL (4)
  ) dut_a (
    .Clk (Clk), .Rst (Rst), .Start (Start),
    .Pause (Pause), .Stop (Stop),
    .TmrTick (TmrTick), .TmrEnable (en_a),
    .TmrClear (clr_a), .TmrCfg (cfg_a),
    .GameTick (gt_a), .Level (lvl_a),
    .Running (run_a)
  );

  rctimer_speed_ctrl #(
    .INIT_PERIOD     (10'd60),
    .MIN_PERIOD      (10'd50),
    .PERIOD_STEP     (10'd25),
    .TICKS_PER_LEVEL (2)
  ) dut_b (
    .Clk (Clk), .Rst (Rst), .Start (Start),
    .Pause (Pause), .Stop (Stop),
    .TmrTick (TmrTick), .TmrEnable (en_b),
    .TmrClear (clr_b), .TmrCfg (cfg_b),
    .GameTick (gt_b), .Level (lvl_b),
    .Running (run_b)
  );

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_RUN    = 2;
  localparam int P_PAUSED = 3;
  localparam int P_HALT   = 4;

  // total = accepted ticks since the last LOAD;
  // level and period follow from it arithmetically
  typedef struct {
    int phase;
    int total;
    bit gt;
    bit pulse;
  } mdl_t;

  typedef struct {
    int init;
    int minp;
    int step;
    int tpl;
    int maxl;
  } prm_t;

  prm_t pa = '{500, 50, 25, 4, 15};
  prm_t pb = '{60, 50, 25, 2, 15};
  mdl_t ma, mb;

  function automatic mdl_t mstep(
    mdl_t m, prm_t p, bit st, bit pz, bit sp, bit tk
  );
    mdl_t n = m;
    n.gt = 1'b0;
    n.pulse = 1'b0;
    case (m.phase)
      P_IDLE, P_HALT: if (st) n.phase = P_LOAD;
      P_LOAD: begin
        n.total = 0;
        n.phase = P_RUN;
      end
      P_RUN: begin
        if (sp) n.phase = P_HALT;
        else begin
          if (tk) begin
            n.total = n.total + 1;
            n.gt = 1'b1;
            n.pulse = (n.total % p.tpl) == 0;
          end
          if (pz) n.phase = P_PAUSED;
        end
      end
      P_PAUSED: begin
        if (sp) n.phase = P_HALT;
        else if (pz) n.phase = P_RUN;
      end
      default: n.phase = P_IDLE;
    endcase
    return n;
  endfunction

  function automatic int exp_lvl(mdl_t m, prm_t p);
    int k = m.total / p.tpl;
    return (k > p.maxl) ? p.maxl : k;
  endfunction

  function automatic int exp_cfg(mdl_t m, prm_t p);
    int c = p.init - p.step * (m.total / p.tpl);
    return (c < p.minp) ? p.minp : c;
  endfunction

  function automatic bit exp_clr(mdl_t m);
    return m.phase == P_IDLE || m.phase == P_LOAD ||
           m.phase == P_HALT || m.pulse;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] expv
  );
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, expv, $time);
    end
  endtask

  task automatic cmp_model();
    chk("a.en", 32'(en_a), 32'(ma.phase == P_RUN));
    chk("a.run", 32'(run_a), 32'(ma.phase == P_RUN));
    chk("a.clr", 32'(clr_a), 32'(exp_clr(ma)));
    chk("a.gt", 32'(gt_a), 32'(ma.gt));
    chk("a.lvl", 32'(lvl_a), exp_lvl(ma, pa));
    chk("a.cfg", 32'(cfg_a), exp_cfg(ma, pa));
    chk("b.en", 32'(en_b), 32'(mb.phase == P_RUN));
    chk("b.run", 32'(run_b), 32'(mb.phase == P_RUN));
    chk("b.clr", 32'(clr_b), 32'(exp_clr(mb)));
    chk("b.gt", 32'(gt_b), 32'(mb.gt));
    chk("b.lvl", 32'(lvl_b), exp_lvl(mb, pb));
    chk("b.cfg", 32'(cfg_b), exp_cfg(mb, pb));
  endtask

  task automatic cyc(bit st, bit pz, bit sp, bit tk);
    Start = st;
    Pause = pz;
    Stop = sp;
    TmrTick = tk;
    @(posedge Clk);
    ma = mstep(ma, pa, st, pz, sp, tk);
    mb = mstep(mb, pb, st, pz, sp, tk);
    @(negedge Clk);
    Start = 1'b0;
    Pause = 1'b0;
    Stop = 1'b0;
    TmrTick = 1'b0;
    cmp_model();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    ma = '{P_IDLE, 0, 1'b0, 1'b0};
    mb = '{P_IDLE, 0, 1'b0, 1'b0};
    #3;
    cmp_model();
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    cmp_model();
  endtask

  typedef struct {
    bit st, pz, sp, tk;
    bit gt;
    int lvl;
    int cfg;
    bit en, clr, run;
  } vec_t;

  vec_t tv[22];

  initial begin
    tv[0]  = '{1,0,0,0, 0,0,500, 0,1,0};
    tv[1]  = '{0,0,0,0, 0,0,500, 1,0,1};
    tv[2]  = '{0,0,0,1, 1,0,500, 1,0,1};
    tv[3]  = '{0,0,0,0, 0,0,500, 1,0,1};
    tv[4]  = '{0,0,0,1, 1,0,500, 1,0,1};
    tv[5]  = '{0,0,0,1, 1,0,500, 1,0,1};
    tv[6]  = '{0,0,0,1, 1,1,475, 1,1,1};
    tv[7]  = '{0,0,0,0, 0,1,475, 1,0,1};
    tv[8]  = '{0,1,0,1, 1,1,475, 0,0,0};
    tv[9]  = '{0,0,0,1, 0,1,475, 0,0,0};
    tv[10] = '{0,0,0,1, 0,1,475, 0,0,0};
    tv[11] = '{0,0,0,1, 0,1,475, 0,0,0};
    tv[12] = '{0,1,0,0, 0,1,475, 1,0,1};
    tv[13] = '{0,0,0,1, 1,1,475, 1,0,1};
    tv[14] = '{0,0,0,1, 1,1,475, 1,0,1};
    tv[15] = '{0,0,0,1, 1,2,450, 1,1,1};
    tv[16] = '{0,0,1,1, 0,2,450, 0,1,0};
    tv[17] = '{0,1,0,0, 0,2,450, 0,1,0};
    tv[18] = '{1,0,0,0, 0,2,450, 0,1,0};
    tv[19] = '{0,0,0,0, 0,0,500, 1,0,1};
    tv[20] = '{1,0,0,0, 0,0,500, 1,0,1};
    tv[21] = '{0,0,1,0, 0,0,500, 0,1,0};

    do_reset();
    chk("rst.cfg", 32'(cfg_a), 500);
    chk("rst.clr", 32'(clr_a), 1);
    chk("rst.en", 32'(en_a), 0);

    for (int i = 0; i < 22; i++) begin
      cyc(tv[i].st, tv[i].pz, tv[i].sp, tv[i].tk);
      chk($sformatf("tv%0d.gt", i), 32'(gt_a), 32'(tv[i].gt));
      chk($sformatf("tv%0d.lvl", i), 32'(lvl_a), tv[i].lvl);
      chk($sformatf("tv%0d.cfg", i), 32'(cfg_a), tv[i].cfg);
      chk($sformatf("tv%0d.en", i), 32'(en_a), 32'(tv[i].en));
      chk($sformatf("tv%0d.clr", i), 32'(clr_a), 32'(tv[i].clr));
      chk($sformatf("tv%0d.run", i), 32'(run_a), 32'(tv[i].run));
    end

    // period floor and level saturation
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      cyc(0, 0, 0, 1);
      if (i == 1) chk("floor.cfg1", 32'(cfg_b), 60);
      if (i == 2) begin
        chk("floor.cfg2", 32'(cfg_b), 50);
        chk("floor.lvl2", 32'(lvl_b), 1);
      end
      if (i == 30) chk("sat.lvl30", 32'(lvl_b), 15);
      if (i == 32) begin
        chk("sat.lvl32", 32'(lvl_b), 15);
        chk("floor.cfg32", 32'(cfg_b), 50);
      end
    end

    // asynchronous reset mid-run drops a pending tick
    cyc(0, 0, 0, 1);
    chk("pre.gt", 32'(gt_a), 1);
    #0.4;
    Rst = 1'b1;
    #0.2;
    chk("arst.gt", 32'(gt_a), 0);
    chk("arst.en", 32'(en_a), 0);
    chk("arst.clr", 32'(clr_a), 1);
    chk("arst.run", 32'(run_a), 0);
    chk("arst.lvl", 32'(lvl_b), 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 4,
          $urandom_range(99) < 6,
          $urandom_range(99) < 3,
          $urandom_range(99) < 45);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
